// File: rtl/fsm_control_llenado_ventana_param.sv
// Window-fill controller: reads FILAS_VENTANA pixels per window position and scans the whole image.
// Optional read timeout with error_lectura_o pulse is enabled by defining TIMEOUT_LECTURA_EN.
//
// state        | meaning
// E_INICIO     | idle, bus released, waiting for iniciar
// E_PEDIR      | one-cycle read request at dir_mem
// E_ESPERAR    | waiting for memory data valid
// E_GUARDAR    | store returned pixel into row indice_fila
// E_VENTANA    | window complete pulse
// E_ESPERA_ACT | waiting for datapath to consume the window
// E_FIN        | scan finished pulse
module fsm_control_llenado_ventana_param #(
  parameter int FILAS_VENTANA = 3,
  parameter int ANCHO_IMAGEN  = 8,
  parameter int ALTO_IMAGEN   = 8,
  parameter int ANCHO_DIR     = 16,
  parameter int LIMITE_ESPERA = 15,
  localparam int W_IDX = (FILAS_VENTANA > 1) ? $clog2(FILAS_VENTANA) : 1,
  localparam int W_COL = $clog2(ANCHO_IMAGEN) + 1,
  localparam int W_FIL = $clog2(ALTO_IMAGEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 iniciar_i,
  input  logic                 dato_leido_disponible_i,
  input  logic                 actualizar_ventana_i,
  output logic                 leer_dato_o,
  output logic [ANCHO_DIR-1:0] dir_mem_o,
  output logic                 guardar_fila_o,
  output logic [W_IDX-1:0]     indice_fila_o,
  output logic                 liberar_bus_mem_o,
  output logic                 ventana_completa_o,
  output logic [W_COL-1:0]     columna_o,
  output logic [W_FIL-1:0]     fila_base_o,
  output logic                 ocupado_o,
`ifdef TIMEOUT_LECTURA_EN
  output logic                 error_lectura_o,
`endif
  output logic                 fin_o
);

  typedef enum logic [2:0] {
    E_INICIO     = 3'd0,
    E_PEDIR      = 3'd1,
    E_ESPERAR    = 3'd2,
    E_GUARDAR    = 3'd3,
    E_VENTANA    = 3'd4,
    E_ESPERA_ACT = 3'd5,
    E_FIN        = 3'd6
  } estado_t;

  localparam logic [W_IDX-1:0] IDX_ULT = W_IDX'(FILAS_VENTANA - 1);
  localparam logic [W_COL-1:0] COL_ULT = W_COL'(ANCHO_IMAGEN - 1);
  localparam logic [W_FIL-1:0] FB_ULT  = W_FIL'(ALTO_IMAGEN - FILAS_VENTANA);

  estado_t              estado_q, estado_d;
  logic [W_IDX-1:0]     idx_q, idx_d;
  logic [W_COL-1:0]     col_q, col_d;
  logic [W_FIL-1:0]     fb_q, fb_d;
  logic [ANCHO_DIR-1:0] dir_q, dir_d;
  logic [ANCHO_DIR-1:0] fila_abs;

`ifdef TIMEOUT_LECTURA_EN
  localparam int W_CNT = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;
  localparam logic [W_CNT-1:0] CNT_INI = W_CNT'(LIMITE_ESPERA - 1);
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             error_d;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      estado_q <= E_INICIO;
      idx_q    <= '0;
      col_q    <= '0;
      fb_q     <= '0;
      dir_q    <= '0;
`ifdef TIMEOUT_LECTURA_EN
      cnt_q    <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      fb_q     <= fb_d;
      dir_q    <= dir_d;
`ifdef TIMEOUT_LECTURA_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    estado_d           = estado_q;
    idx_d              = idx_q;
    col_d              = col_q;
    fb_d               = fb_q;
    leer_dato_o        = 1'b0;
    guardar_fila_o     = 1'b0;
    ventana_completa_o = 1'b0;
    fin_o              = 1'b0;
`ifdef TIMEOUT_LECTURA_EN
    cnt_d              = cnt_q;
    error_d            = 1'b0;
`endif
    case (estado_q)
      E_INICIO: begin
        if (iniciar_i) begin
          estado_d = E_PEDIR;
          idx_d    = '0;
          col_d    = '0;
          fb_d     = '0;
        end
      end
      E_PEDIR: begin
        leer_dato_o = 1'b1;
        estado_d    = E_ESPERAR;
`ifdef TIMEOUT_LECTURA_EN
        cnt_d       = CNT_INI;
`endif
      end
      E_ESPERAR: begin
        if (dato_leido_disponible_i) begin
          estado_d = E_GUARDAR;
`ifdef TIMEOUT_LECTURA_EN
        end else if (cnt_q == '0) begin
          // same address and row are reissued since counters are untouched
          error_d  = 1'b1;
          estado_d = E_PEDIR;
        end else begin
          cnt_d    = cnt_q - 1'b1;
`endif
        end
      end
      E_GUARDAR: begin
        guardar_fila_o = 1'b1;
        if (idx_q == IDX_ULT) begin
          estado_d = E_VENTANA;
        end else begin
          idx_d    = idx_q + 1'b1;
          estado_d = E_PEDIR;
        end
      end
      E_VENTANA: begin
        ventana_completa_o = 1'b1;
        estado_d           = E_ESPERA_ACT;
      end
      E_ESPERA_ACT: begin
        if (actualizar_ventana_i) begin
          if (col_q == COL_ULT && fb_q == FB_ULT) begin
            estado_d = E_FIN;
          end else begin
            if (col_q == COL_ULT) begin
              col_d = '0;
              fb_d  = fb_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            idx_d    = '0;
            estado_d = E_PEDIR;
          end
        end
      end
      E_FIN: begin
        fin_o    = 1'b1;
        estado_d = E_INICIO;
        idx_d    = '0;
        col_d    = '0;
        fb_d     = '0;
      end
      default: begin
        estado_d = E_INICIO;
        idx_d    = '0;
        col_d    = '0;
        fb_d     = '0;
      end
    endcase

    // address follows the next counter values so it is valid on entry to E_PEDIR
    fila_abs = ANCHO_DIR'(fb_d) + ANCHO_DIR'(idx_d);
    dir_d    = fila_abs * ANCHO_DIR'(ANCHO_IMAGEN) + ANCHO_DIR'(col_d);
  end

`ifdef TIMEOUT_LECTURA_EN
  assign error_lectura_o = error_d;
`endif

  assign dir_mem_o         = dir_q;
  assign indice_fila_o     = idx_q;
  assign columna_o         = col_q;
  assign fila_base_o       = fb_q;
  assign ocupado_o         = (estado_q != E_INICIO);
  assign liberar_bus_mem_o = reset_i & ((estado_q == E_INICIO) || (estado_q == E_VENTANA) ||
                                        (estado_q == E_ESPERA_ACT) || (estado_q == E_FIN));

endmodule
